hilo_muldiv_unit: RTL and testbench

Parametrised, iterative multiply/divide unit that owns the HI/LO register pair for the multicycle MIPS datapath. It executes MULT, MULTU, DIV and DIVU over SIZE+1 cycles, exposing Busy/Done so the control FSM can stall MFHI/MFLO. It also supports direct MTHI/MTLO writes. It succeeds the fixed single-cycle HI/LO register.

---
 rtl/hilo_muldiv_unit.sv | 137 +++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; results land SIZE+1 cycles after an accepted Start.
// Optional macro HILO_DIV0_EN: divide by zero short-circuits in one cycle and pulses DivZero.
module hilo_muldiv_unit #(
   parameter int SIZE = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            Start,
   input  logic [1:0]      Op,
   input  logic [SIZE-1:0] SrcA,
   input  logic [SIZE-1:0] SrcB,
   input  logic [SIZE-1:0] WrData,
   input  logic            HEN,
   input  logic            LEN,
   output logic            Busy,
   output logic            Done,
   output logic            DivZero,
   output logic [SIZE-1:0] hi,
   output logic [SIZE-1:0] lo
);
   localparam int CW = $clog2(SIZE);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [1:0]        op_r;
   logic              neg_a, neg_b, dz_pend;
   logic [SIZE-1:0]   acc_hi, acc_lo, opb;

   logic              is_signed;
   logic [SIZE-1:0]   mag_a, mag_b;
   logic [SIZE:0]     sum;
   logic [SIZE-1:0]   shl_lo;
   logic [SIZE:0]     diff;
   logic              ge;
   logic [SIZE-1:0]   step_hi, step_lo;
   logic [2*SIZE-1:0] prod, prod_fix;
   logic [SIZE-1:0]   quo_fix, rem_fix;

   always_comb begin
      is_signed = ~Op[0];
      mag_a     = (is_signed && SrcA[SIZE-1]) ? -SrcA : SrcA;
      mag_b     = (is_signed && SrcB[SIZE-1]) ? -SrcB : SrcB;

      // Multiply: acc_lo holds the multiplier and shifts product bits in from the top.
      sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

      // Divide: the partial remainder stays below the divisor, so a set top bit of
      // acc_hi guarantees the shifted value exceeds it and the low bits are exact.
      shl_lo = {acc_hi[SIZE-2:0], acc_lo[SIZE-1]};
      diff   = {1'b0, shl_lo} - {1'b0, opb};
      ge     = acc_hi[SIZE-1] | ~diff[SIZE];

      if (op_r[1]) begin
         step_hi = ge ? diff[SIZE-1:0] : shl_lo;
         step_lo = {acc_lo[SIZE-2:0], ge};
      end else begin
         step_hi = sum[SIZE:1];
         step_lo = {sum[0], acc_lo[SIZE-1:1]};
      end

      prod     = {acc_hi, acc_lo};
      prod_fix = (~op_r[0] & (neg_a ^ neg_b)) ? -prod : prod;
      quo_fix  = (~op_r[0] & (neg_a ^ neg_b)) ? -acc_lo : acc_lo;
      rem_fix  = (~op_r[0] & neg_a) ? -acc_hi : acc_hi;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         cnt     <= '0;
         op_r    <= 2'b00;
         neg_a   <= 1'b0;
         neg_b   <= 1'b0;
         dz_pend <= 1'b0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opb     <= '0;
         hi      <= '0;
         lo      <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         DivZero <= 1'b0;
      end else begin
         Done    <= 1'b0;
         DivZero <= 1'b0;
         case (state)
            IDLE: begin
               if (HEN) hi <= WrData;
               if (LEN) lo <= WrData;
               if (Start) begin
                  op_r    <= Op;
                  neg_a   <= is_signed & SrcA[SIZE-1];
                  neg_b   <= is_signed & SrcB[SIZE-1];
                  acc_hi  <= '0;
                  acc_lo  <= mag_a;
                  opb     <= mag_b;
                  cnt     <= '0;
                  dz_pend <= 1'b0;
                  Busy    <= 1'b1;
                  state   <= CALC;
`ifdef HILO_DIV0_EN
                  if (Op[1] && (SrcB == '0)) begin
                     dz_pend <= 1'b1;
                     acc_hi  <= SrcA;
                     state   <= FIX;
                  end
`endif
               end
            end
            CALC: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(SIZE-1)) state <= FIX;
            end
            FIX: begin
               if (dz_pend) begin
                  hi      <= acc_hi;
                  lo      <= '1;
                  DivZero <= 1'b1;
               end else if (op_r[1]) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
               Done  <= 1'b1;
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit (SIZE=32); honours HILO_DIV0_EN when defined.
module tb_hilo_muldiv_unit;
   localparam int SIZE = 32;
   localparam int LAT  = SIZE + 1;

   logic        CLK, RST, Start, HEN, LEN;
   logic [1:0]  Op;
   logic [31:0] SrcA, SrcB, WrData;
   logic        Busy, Done, DivZero;
   logic [31:0] hi, lo;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          edge_cnt = 0;
   int          start_edge = 0;
   logic [63:0] exp_q[$];
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   hilo_muldiv_unit #(.SIZE(SIZE)) dut (
      .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
      .WrData(WrData), .HEN(HEN), .LEN(LEN), .Busy(Busy), .Done(Done),
      .DivZero(DivZero), .hi(hi), .lo(lo)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint pa, pb;
      int sa, sb, qi, ri;
      logic [63:0] r;
      if (op[1] && b == 32'h0) begin
         r = {a, 32'hFFFFFFFF};
      end else begin
         case (op)
            2'b00: begin
               pa = longint'($signed(a));
               pb = longint'($signed(b));
               r  = pa * pb;
            end
            2'b01: r = {32'h0, a} * {32'h0, b};
            2'b10: begin
               if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                  r = {32'h0, 32'h80000000};
               end else begin
                  sa = $signed(a);
                  sb = $signed(b);
                  qi = sa / sb;
                  ri = sa % sb;
                  r  = {ri, qi};
               end
            end
            default: r = {a % b, a / b};
         endcase
      end
      return r;
   endfunction

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
      @(negedge CLK);
      Start = 1'b1; Op = op; SrcA = a; SrcB = b;
      if (push) exp_q.push_back(model(op, a, b));
      @(posedge CLK);
      #1;
      start_edge = edge_cnt;
      Start = 1'b0;
   endtask

   task automatic wait_result(output int lat, output int bcyc, output logic [31:0] h,
                              output logic [31:0] l, output logic dz, output bit seen);
      seen = 1'b0; lat = 0; h = '0; l = '0; dz = 1'b0;
      bcyc = Busy ? 1 : 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge CLK);
         #1;
         if (Done) begin
            seen = 1'b1; lat = edge_cnt - start_edge;
            h = hi; l = lo; dz = DivZero;
            break;
         end
         if (Busy) bcyc++;
      end
   endtask

   task automatic test_reset();
      @(negedge CLK);
      #1;
      n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL rst_hilo got %h want 0", {hi, lo}); end
      n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", Busy); end
      n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", Done); end
      n_cmp++; if (DivZero !== 1'b0) begin n_bad++; $display("FAIL rst_dz got %b want 0", DivZero); end
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      n_cmp++; if ({Busy, Done, hi, lo} !== 66'h0) begin
         n_bad++; $display("FAIL idle_after_rst got %b%b %h %h want all 0", Busy, Done, hi, lo);
      end
   endtask

   task automatic test_mul();
      logic [1:0] op; logic [31:0] a, b, h, l; logic [63:0] e;
      int lat, bc; logic dz; bit seen;
      for (int k = 0; k < 5; k++) begin
         case (k)
            0: begin op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
            1: begin op = 2'b00; a = 32'hFFFFFFFD; b = 32'd5; end
            2: begin op = 2'b00; a = 32'h80000000; b = 32'h80000000; end
            3: begin op = 2'b00; a = $urandom; b = $urandom; end
            default: begin op = 2'b01; a = $urandom; b = $urandom; end
         endcase
         issue(op, a, b, 1'b1);
         wait_result(lat, bc, h, l, dz, seen);
         e = exp_q.pop_front();
         last_hi = e[63:32]; last_lo = e[31:0];
         n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL mul%0d_done_timeout got %b want 1", k, seen); end
         n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL mul%0d_latency got %0d want %0d", k, lat, LAT); end
         n_cmp++; if (bc != LAT) begin n_bad++; $display("FAIL mul%0d_busy_cycles got %0d want %0d", k, bc, LAT); end
         n_cmp++; if ({h, l} !== e) begin n_bad++; $display("FAIL mul%0d_hilo got %h want %h", k, {h, l}, e); end
      end
   endtask

   task automatic test_div();
      logic [1:0] op; logic [31:0] a, b, h, l; logic [63:0] e;
      int lat, bc; logic dz; bit seen;
      for (int k = 0; k < 6; k++) begin
         case (k)
            0: begin op = 2'b10; a = 32'hFFFFFFF9; b = 32'd2; end
            1: begin op = 2'b11; a = 32'd100; b = 32'd7; end
            2: begin op = 2'b10; a = 32'h80000000; b = 32'hFFFFFFFF; end
            3: begin op = 2'b10; a = 32'd17; b = 32'hFFFFFFFB; end
            4: begin op = 2'b10; a = $urandom; b = -32'($urandom_range(1, 3000)); end
            default: begin op = 2'b11; a = $urandom; b = 32'($urandom_range(1, 70000)); end
         endcase
         issue(op, a, b, 1'b1);
         wait_result(lat, bc, h, l, dz, seen);
         e = exp_q.pop_front();
         last_hi = e[63:32]; last_lo = e[31:0];
         n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL div%0d_done_timeout got %b want 1", k, seen); end
         n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL div%0d_latency got %0d want %0d", k, lat, LAT); end
         n_cmp++; if ({h, l} !== e) begin n_bad++; $display("FAIL div%0d_hilo got %h want %h", k, {h, l}, e); end
         n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL div%0d_divzero got %b want 0", k, dz); end
      end
   endtask

   task automatic test_mt();
      logic [31:0] h, l; logic [63:0] e;
      int lat, bc; logic dz; bit seen;
      @(negedge CLK); HEN = 1'b1; WrData = 32'h1234;
      @(posedge CLK); #1; HEN = 1'b0;
      n_cmp++; if ({hi, lo} !== {32'h1234, last_lo}) begin
         n_bad++; $display("FAIL mthi got %h want %h", {hi, lo}, {32'h1234, last_lo});
      end
      last_hi = 32'h1234;
      @(negedge CLK); LEN = 1'b1; WrData = 32'hCAFEF00D;
      @(posedge CLK); #1; LEN = 1'b0;
      n_cmp++; if ({hi, lo} !== {last_hi, 32'hCAFEF00D}) begin
         n_bad++; $display("FAIL mtlo got %h want %h", {hi, lo}, {last_hi, 32'hCAFEF00D});
      end
      @(negedge CLK); HEN = 1'b1; LEN = 1'b1; WrData = 32'hA5A5A5A5;
      @(posedge CLK); #1; HEN = 1'b0; LEN = 1'b0;
      n_cmp++; if ({hi, lo} !== {2{32'hA5A5A5A5}}) begin
         n_bad++; $display("FAIL mt_both got %h want %h", {hi, lo}, {2{32'hA5A5A5A5}});
      end
      // MTHI in the same cycle as an accepted Start: written now, overwritten by the result.
      @(negedge CLK);
      Start = 1'b1; Op = 2'b01; SrcA = 32'd6; SrcB = 32'd7; HEN = 1'b1; WrData = 32'h77;
      exp_q.push_back(model(2'b01, 32'd6, 32'd7));
      @(posedge CLK); #1;
      start_edge = edge_cnt; Start = 1'b0; HEN = 1'b0;
      n_cmp++; if (hi !== 32'h77) begin n_bad++; $display("FAIL mt_with_start got %h want 00000077", hi); end
      wait_result(lat, bc, h, l, dz, seen);
      e = exp_q.pop_front();
      last_hi = e[63:32]; last_lo = e[31:0];
      n_cmp++; if (seen !== 1'b1 || lat != LAT) begin
         n_bad++; $display("FAIL mt_start_latency got %0d seen %b want %0d", lat, seen, LAT);
      end
      n_cmp++; if ({h, l} !== e) begin n_bad++; $display("FAIL mt_start_hilo got %h want %h", {h, l}, e); end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] h, l; logic [63:0] e;
      int lat, bc; logic dz; bit seen;
      issue(2'b01, 32'h00012345, 32'h00006789, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         Start = 1'b1; HEN = 1'b1; LEN = 1'b1; WrData = $urandom;
         SrcA = $urandom; SrcB = $urandom; Op = 2'($urandom_range(0, 3));
         @(posedge CLK); #1;
         Start = 1'b0; HEN = 1'b0; LEN = 1'b0;
         n_cmp++; if ({hi, lo} !== {last_hi, last_lo}) begin
            n_bad++; $display("FAIL busy_mt%0d got %h want %h", k, {hi, lo}, {last_hi, last_lo});
         end
      end
      wait_result(lat, bc, h, l, dz, seen);
      e = exp_q.pop_front();
      last_hi = e[63:32]; last_lo = e[31:0];
      n_cmp++; if (seen !== 1'b1 || lat != LAT) begin
         n_bad++; $display("FAIL busy_latency got %0d seen %b want %0d", lat, seen, LAT);
      end
      n_cmp++; if ({h, l} !== e) begin n_bad++; $display("FAIL busy_hilo got %h want %h", {h, l}, e); end
      repeat (3) @(posedge CLK);
      #1;
      n_cmp++; if ({Busy, Done} !== 2'b00) begin
         n_bad++; $display("FAIL busy_no_queue got %b%b want 00", Busy, Done);
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] h, l; logic [63:0] e;
      int lat, bc, dcnt; logic dz; bit seen;
      issue(2'b01, 32'hDEADBEEF, 32'd3, 1'b0);
      repeat (10) @(posedge CLK);
      @(negedge CLK); RST = 1'b0; #1;
      n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL midrst_hilo got %h want 0", {hi, lo}); end
      n_cmp++; if ({Busy, Done} !== 2'b00) begin n_bad++; $display("FAIL midrst_busy_done got %b%b want 00", Busy, Done); end
      @(negedge CLK); RST = 1'b1;
      last_hi = '0; last_lo = '0;
      dcnt = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge CLK); #1;
         if (Done || Busy) dcnt++;
      end
      n_cmp++; if (dcnt != 0) begin n_bad++; $display("FAIL midrst_ghost_result got %0d cycles want 0", dcnt); end
      n_cmp++; if ({hi, lo} !== 64'h0) begin n_bad++; $display("FAIL midrst_hold got %h want 0", {hi, lo}); end
      issue(2'b01, 32'd6, 32'd7, 1'b1);
      wait_result(lat, bc, h, l, dz, seen);
      e = exp_q.pop_front();
      last_hi = e[63:32]; last_lo = e[31:0];
      n_cmp++; if (seen !== 1'b1 || lat != LAT) begin
         n_bad++; $display("FAIL postrst_latency got %0d seen %b want %0d", lat, seen, LAT);
      end
      n_cmp++; if ({h, l} !== 64'd42) begin n_bad++; $display("FAIL postrst_hilo got %h want %h", {h, l}, 64'd42); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] op; logic [31:0] a, b, h, l; logic [63:0] e;
      int lat, bc; logic dz; bit seen;
      for (int k = 0; k < 6; k++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = op[1] ? 32'($urandom_range(1, 100000)) : $urandom;
         if (op == 2'b10 && $urandom_range(0, 1) == 1) b = -b;
         issue(op, a, b, 1'b1);
         wait_result(lat, bc, h, l, dz, seen);
         e = exp_q.pop_front();
         last_hi = e[63:32]; last_lo = e[31:0];
         n_cmp++; if (seen !== 1'b1 || lat != LAT) begin
            n_bad++; $display("FAIL b2b%0d_latency got %0d seen %b want %0d", k, lat, seen, LAT);
         end
         n_cmp++; if ({h, l} !== e) begin
            n_bad++; $display("FAIL b2b%0d_hilo op %0d a %h b %h got %h want %h", k, op, a, b, {h, l}, e);
         end
      end
   endtask

   task automatic test_div0();
      logic [31:0] h, l; logic [63:0] e;
      int lat, bc; logic dz; bit seen;
`ifdef HILO_DIV0_EN
      issue(2'b11, 32'h55, 32'h0, 1'b1);
      wait_result(lat, bc, h, l, dz, seen);
      e = exp_q.pop_front();
      n_cmp++; if (seen !== 1'b1 || lat != 1) begin
         n_bad++; $display("FAIL div0_latency got %0d seen %b want 1", lat, seen);
      end
      n_cmp++; if (bc != 1) begin n_bad++; $display("FAIL div0_busy_cycles got %0d want 1", bc); end
      n_cmp++; if (dz !== 1'b1) begin n_bad++; $display("FAIL div0_divzero got %b want 1", dz); end
      n_cmp++; if ({h, l} !== e) begin n_bad++; $display("FAIL div0_hilo got %h want %h", {h, l}, e); end
`else
      issue(2'b11, 32'h55, 32'h0, 1'b0);
      wait_result(lat, bc, h, l, dz, seen);
      n_cmp++; if (seen !== 1'b1 || lat != LAT) begin
         n_bad++; $display("FAIL div0_latency got %0d seen %b want %0d", lat, seen, LAT);
      end
      n_cmp++; if (bc != LAT) begin n_bad++; $display("FAIL div0_busy_cycles got %0d want %0d", bc, LAT); end
      n_cmp++; if (dz !== 1'b0) begin n_bad++; $display("FAIL div0_divzero got %b want 0", dz); end
`endif
   endtask

   initial begin
      RST = 1'b0; Start = 1'b0; HEN = 1'b0; LEN = 1'b0;
      Op = 2'b00; SrcA = '0; SrcB = '0; WrData = '0;
      repeat (2) @(posedge CLK);
      test_reset();
      test_mul();
      test_div();
      test_mt();
      test_busy_ignore();
      test_reset_midop();
      test_back_to_back();
      test_div0();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
